// File: rtl/cnn_pkg.sv
// Shared constants, state encoding and result conversion for the conv/pool engine.
package cnn_pkg;

    localparam int DATA_W = 8;
    localparam int ACC_W  = 21;
    localparam int PIX_N  = 16;
    localparam int K3_N   = 9;
    localparam int K2_N   = 4;
    localparam int LOAD_N = PIX_N + K3_N + K2_N;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        CONV3 = 2'd1,
        CONV2 = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Clamp an already-shifted sum into the unsigned 8-bit output range.
    function automatic logic [DATA_W-1:0] clamp_u8(input logic signed [ACC_W-1:0] v);
        logic [DATA_W-1:0] r;
        if (v < 21'sd0) begin
            r = 8'd0;
        end else if (v > 21'sd255) begin
            r = 8'd255;
        end else begin
            r = v[DATA_W-1:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/mac_unit.sv
// One unsigned-pixel x signed-weight multiply and 21-bit accumulate per enabled cycle.
module mac_unit
    import cnn_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     enable,
    input  logic [DATA_W-1:0]        pixel,
    input  logic signed [DATA_W-1:0] weight,
    output logic signed [ACC_W-1:0]  acc
);

    logic signed [DATA_W:0]     pix_s;
    logic signed [2*DATA_W:0]   prod_s;
    logic signed [ACC_W-1:0]    prod_ext_s;

    assign pix_s      = {1'b0, pixel};
    assign prod_s     = pix_s * weight;
    assign prod_ext_s = {{(ACC_W-2*DATA_W-1){prod_s[2*DATA_W]}}, prod_s};

    // Accumulator: a clear tap restarts the window sum with the current product.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc <= 21'sd0;
        end else if (enable) begin
            if (clear) begin
                acc <= prod_ext_s;
            end else begin
                acc <= acc + prod_ext_s;
            end
        end else begin
            acc <= acc;
        end
    end

endmodule

// File: rtl/conv_pool_engine.sv
// Loads a 4x4 image plus 3x3 and 2x2 kernels, then computes 4+4 clamped convolution cells.
module conv_pool_engine
    import cnn_pkg::*;
#(
    parameter int SHIFT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] cell_3x3_11,
    output logic [DATA_W-1:0] cell_3x3_12,
    output logic [DATA_W-1:0] cell_3x3_21,
    output logic [DATA_W-1:0] cell_3x3_22,
    output logic [DATA_W-1:0] cell_2x2_11,
    output logic [DATA_W-1:0] cell_2x2_12,
    output logic [DATA_W-1:0] cell_2x2_21,
    output logic [DATA_W-1:0] cell_2x2_22
);

    state_t                   state_r, next_s;
    logic [4:0]               load_cnt_r;
    logic [DATA_W-1:0]        mem_r [LOAD_N];
    logic [1:0]               tap_row_r, tap_col_r, win_r;
    logic [DATA_W-1:0]        hold_r [7];
    logic                     done_r;
    logic [DATA_W-1:0]        cells_r [8];

    logic [2:0]               prow_s, pcol_s, gwin_s;
    logic [4:0]               w_idx_s;
    logic [1:0]               tap_lim_s;
    logic                     mac_en_s, mac_clr_s, win_last_tap_s;
    logic signed [ACC_W-1:0]  acc_s, shifted_s;
    logic [DATA_W-1:0]        conv_s;

    assign in_ready       = (state_r == LOAD);
    assign busy           = (state_r != LOAD);
    assign done           = done_r;
    assign mac_en_s       = (state_r == CONV3) || (state_r == CONV2);
    assign mac_clr_s      = (tap_row_r == 2'd0) && (tap_col_r == 2'd0);
    assign tap_lim_s      = (state_r == CONV2) ? 2'd1 : 2'd2;
    assign win_last_tap_s = (tap_row_r == tap_lim_s) && (tap_col_r == tap_lim_s);
    assign gwin_s         = {(state_r == CONV2), win_r};
    assign shifted_s      = acc_s >>> SHIFT;
    assign conv_s         = clamp_u8(shifted_s);

    assign cell_3x3_11 = cells_r[0];
    assign cell_3x3_12 = cells_r[1];
    assign cell_3x3_21 = cells_r[2];
    assign cell_3x3_22 = cells_r[3];
    assign cell_2x2_11 = cells_r[4];
    assign cell_2x2_12 = cells_r[5];
    assign cell_2x2_21 = cells_r[6];
    assign cell_2x2_22 = cells_r[7];

    // Tap addressing: 3x3 windows step by one pixel, 2x2 windows by two.
    always_comb begin
        prow_s  = 3'd0;
        pcol_s  = 3'd0;
        w_idx_s = 5'd0;
        if (state_r == CONV2) begin
            prow_s  = {win_r[1], 1'b0} + {1'b0, tap_row_r};
            pcol_s  = {win_r[0], 1'b0} + {1'b0, tap_col_r};
            w_idx_s = 5'd25 + {2'b00, tap_row_r, 1'b0} + {3'b000, tap_col_r};
        end else begin
            prow_s  = {2'b00, win_r[1]} + {1'b0, tap_row_r};
            pcol_s  = {2'b00, win_r[0]} + {1'b0, tap_col_r};
            w_idx_s = 5'd16 + {2'b00, tap_row_r, 1'b0} + {3'b000, tap_row_r}
                      + {3'b000, tap_col_r};
        end
    end

    mac_unit u_mac (
        .clk    (clk),
        .rst    (rst),
        .clear  (mac_clr_s),
        .enable (mac_en_s),
        .pixel  (mem_r[{1'b0, prow_s[1:0], pcol_s[1:0]}]),
        .weight (mem_r[w_idx_s]),
        .acc    (acc_s)
    );

    // Next-state decode.
    always_comb begin
        next_s = state_r;
        case (state_r)
            LOAD: begin
                if (in_valid && (load_cnt_r == 5'd28)) next_s = CONV3;
                else                                    next_s = LOAD;
            end
            CONV3: begin
                if (win_last_tap_s && (win_r == 2'd3)) next_s = CONV2;
                else                                   next_s = CONV3;
            end
            CONV2: begin
                if (win_last_tap_s && (win_r == 2'd3)) next_s = DONE;
                else                                   next_s = CONV2;
            end
            DONE:    next_s = LOAD;
            default: next_s = LOAD;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_r <= LOAD;
        else      state_r <= next_s;
    end

    // Load buffer, tap/window counters, per-window result capture and output update.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            load_cnt_r <= 5'd0;
            tap_row_r  <= 2'd0;
            tap_col_r  <= 2'd0;
            win_r      <= 2'd0;
            done_r     <= 1'b0;
            for (int i = 0; i < LOAD_N; i++) mem_r[i]   <= 8'd0;
            for (int i = 0; i < 7; i++)      hold_r[i]  <= 8'd0;
            for (int i = 0; i < 8; i++)      cells_r[i] <= 8'd0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                LOAD: begin
                    if (in_valid) begin
                        mem_r[load_cnt_r] <= in_data;
                        load_cnt_r <= (load_cnt_r == 5'd28) ? 5'd0 : load_cnt_r + 5'd1;
                    end
                end
                CONV3, CONV2: begin
                    // The first tap of a window still sees the previous window's final sum.
                    if (mac_clr_s && (gwin_s != 3'd0)) hold_r[gwin_s - 3'd1] <= conv_s;
                    if (tap_col_r == tap_lim_s) begin
                        tap_col_r <= 2'd0;
                        if (tap_row_r == tap_lim_s) begin
                            tap_row_r <= 2'd0;
                            win_r     <= win_r + 2'd1;
                        end else begin
                            tap_row_r <= tap_row_r + 2'd1;
                        end
                    end else begin
                        tap_col_r <= tap_col_r + 2'd1;
                    end
                end
                DONE: begin
                    for (int i = 0; i < 7; i++) cells_r[i] <= hold_r[i];
                    cells_r[7] <= conv_s;
                    done_r     <= 1'b1;
                    tap_row_r  <= 2'd0;
                    tap_col_r  <= 2'd0;
                    win_r      <= 2'd0;
                end
                default: begin
                    load_cnt_r <= 5'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_conv_pool_engine.sv
// Directed self-checking bench for conv_pool_engine with hand-computed expected cells.
module tb_conv_pool_engine;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready, busy, done;
    logic [7:0] c3_11, c3_12, c3_21, c3_22, c2_11, c2_12, c2_21, c2_22;

    int         n_pass  = 0;
    int         n_total = 0;
    logic [7:0] vec [29];

    always #5 clk = ~clk;

    conv_pool_engine #(.SHIFT(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .busy        (busy),
        .done        (done),
        .cell_3x3_11 (c3_11),
        .cell_3x3_12 (c3_12),
        .cell_3x3_21 (c3_21),
        .cell_3x3_22 (c3_22),
        .cell_2x2_11 (c2_11),
        .cell_2x2_12 (c2_12),
        .cell_2x2_21 (c2_21),
        .cell_2x2_22 (c2_22)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    task automatic check_cells(input string tag,
                               input logic [7:0] a, input logic [7:0] b,
                               input logic [7:0] c, input logic [7:0] d,
                               input logic [7:0] e, input logic [7:0] f,
                               input logic [7:0] g, input logic [7:0] h);
        check_val({tag, ".3x3_11"}, {24'd0, c3_11}, {24'd0, a});
        check_val({tag, ".3x3_12"}, {24'd0, c3_12}, {24'd0, b});
        check_val({tag, ".3x3_21"}, {24'd0, c3_21}, {24'd0, c});
        check_val({tag, ".3x3_22"}, {24'd0, c3_22}, {24'd0, d});
        check_val({tag, ".2x2_11"}, {24'd0, c2_11}, {24'd0, e});
        check_val({tag, ".2x2_12"}, {24'd0, c2_12}, {24'd0, f});
        check_val({tag, ".2x2_21"}, {24'd0, c2_21}, {24'd0, g});
        check_val({tag, ".2x2_22"}, {24'd0, c2_22}, {24'd0, h});
    endtask

    task automatic fill(input logic [7:0] pix, input logic [7:0] w3, input logic [7:0] w2);
        for (int i = 0; i < 16; i++)  vec[i] = pix;
        for (int i = 16; i < 25; i++) vec[i] = w3;
        for (int i = 25; i < 29; i++) vec[i] = w2;
    endtask

    task automatic fill_ramp();
        for (int i = 0; i < 16; i++) vec[i] = 8'(i);
        for (int i = 16; i < 29; i++) vec[i] = 8'd0;
        vec[20] = 8'd16;
        vec[25] = 8'd16;
    endtask

    // Drive bytes first..last of vec; each byte is held until an edge with in_ready high.
    task automatic send_bytes(input int first, input int last, input bit gaps);
        for (int i = first; i <= last; i++) begin
            while (gaps && ($urandom_range(0, 1) == 1)) begin
                in_valid = 1'b0;
                in_data  = 8'($urandom_range(0, 255));
                @(posedge clk); #1;
            end
            in_valid = 1'b1;
            in_data  = vec[i];
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
    endtask

    // Count edges from the last accepting edge up to the done pulse.
    task automatic wait_done(input string tag, input bit junk);
        int n;
        bit seen;
        n    = 0;
        seen = 1'b0;
        if (junk) begin
            in_valid = 1'b1;
            in_data  = 8'hFF;
        end
        check_val({tag, ".busy_after_load"}, {31'd0, busy}, 32'd1);
        while (!seen && n < 200) begin
            @(posedge clk); #1;
            n++;
            if (done) seen = 1'b1;
            if (junk && n == 20) check_val({tag, ".ready_while_busy"}, {31'd0, in_ready}, 32'd0);
        end
        in_valid = 1'b0;
        check_val({tag, ".done_latency"}, n, 32'd53);
        @(posedge clk); #1;
        check_val({tag, ".done_one_cycle"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        int pulses;
        rst      = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'd0;
        #3;
        check_cells("reset", 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0);
        check_val("reset.done", {31'd0, done}, 32'd0);
        check_val("reset.busy", {31'd0, busy}, 32'd0);
        check_val("reset.ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;

        fill(8'd16, 8'd1, 8'd1);
        send_bytes(0, 28, 1'b0);
        wait_done("uniform", 1'b0);
        check_cells("uniform", 8'd9, 8'd9, 8'd9, 8'd9, 8'd4, 8'd4, 8'd4, 8'd4);

        fill(8'd255, 8'd127, 8'd127);
        send_bytes(0, 28, 1'b0);
        wait_done("sat", 1'b0);
        check_cells("sat", 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255);

        fill(8'd255, 8'h80, 8'h80);
        send_bytes(0, 19, 1'b0);
        repeat (30) @(posedge clk);
        #1;
        check_val("hold.busy", {31'd0, busy}, 32'd0);
        check_cells("hold", 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255);
        send_bytes(20, 28, 1'b0);
        wait_done("neg", 1'b0);
        check_cells("neg", 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0);

        fill_ramp();
        send_bytes(0, 28, 1'b1);
        wait_done("ramp", 1'b1);
        check_cells("ramp", 8'd5, 8'd6, 8'd9, 8'd10, 8'd0, 8'd2, 8'd8, 8'd10);

        fill(8'd16, 8'd1, 8'd1);
        send_bytes(0, 28, 1'b0);
        wait_done("uniform2", 1'b0);
        check_cells("uniform2", 8'd9, 8'd9, 8'd9, 8'd9, 8'd4, 8'd4, 8'd4, 8'd4);

        fill(8'd255, 8'd127, 8'd127);
        send_bytes(0, 28, 1'b0);
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check_cells("midrst", 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0);
        check_val("midrst.busy", {31'd0, busy}, 32'd0);
        check_val("midrst.ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        rst    = 1'b1;
        pulses = 0;
        for (int i = 0; i < 80; i++) begin
            @(posedge clk); #1;
            if (done) pulses++;
        end
        check_val("midrst.no_done", pulses, 32'd0);
        check_cells("midrst_hold", 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0);

        fill_ramp();
        send_bytes(0, 28, 1'b0);
        wait_done("reload", 1'b0);
        check_cells("reload", 8'd5, 8'd6, 8'd9, 8'd10, 8'd0, 8'd2, 8'd8, 8'd10);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/conv_pool_engine.md
CONV_POOL_ENGINE -- requirements
Module: conv_pool_engine

Interface
REQ-001 SHALL have parameter SHIFT, default 4, giving the arithmetic right shift applied to each accumulator before clamping.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port in_valid, input, 1 bit: in_data holds a valid load byte.
REQ-005 SHALL have port in_data, input, 8 bits: load byte (pixel or weight).
REQ-006 SHALL have port in_ready, output, 1 bit: the block accepts a load byte this cycle.
REQ-007 SHALL have port busy, output, 1 bit: computation in progress.
REQ-008 SHALL have port done, output, 1 bit: one-cycle pulse marking that a new result set is visible.
REQ-009 SHALL have ports cell_3x3_11, cell_3x3_12, cell_3x3_21, cell_3x3_22, each output, 8 bits: 3x3 convolution results.
REQ-010 SHALL have ports cell_2x2_11, cell_2x2_12, cell_2x2_21, cell_2x2_22, each output, 8 bits: 2x2 stride-2 convolution results.

Function
REQ-011 SHALL accept a byte on every cycle where in_valid and in_ready are both high, and on no other cycle.
REQ-012 SHALL take the load stream as 29 bytes in this order:
- 16 unsigned pixels p[r][c], row-major, r,c = 0..3
- 9 signed two's-complement weights k3[a][b], row-major
- 4 signed weights k2[a][b], row-major
REQ-013 SHALL have states LOAD, CONV3, CONV2 and DONE.
- LOAD: in_ready=1, busy=0; the 29th accepted byte moves the block to CONV3.
- CONV3: 36 cycles.
- CONV2: 16 cycles.
- DONE: 1 cycle, then back to LOAD.
- In CONV3, CONV2 and DONE: in_ready=0, busy=1.
REQ-014 SHALL perform exactly one 8x8 signed multiply (pixel zero-extended to 9 bits) and one accumulate per cycle in CONV3 and CONV2.
REQ-015 SHALL use a 21-bit signed accumulator, cleared at the first tap of each window.
REQ-016 SHALL compute cell_3x3_(i+1)(j+1) = sum over a,b = 0..2 of p[i+a][j+b]*k3[a][b], for i,j = 0..1.
REQ-017 SHALL compute cell_2x2_(i+1)(j+1) = sum over a,b = 0..1 of p[2i+a][2j+b]*k2[a][b], for i,j = 0..1.
REQ-018 SHALL evaluate windows in the order 11, 12, 21, 22, with taps row-major inside each window.
REQ-019 SHALL convert each final sum as follows: arithmetic shift right by SHIFT; negative results become 0; results above 255 become 255.
REQ-020 SHALL hold converted values internally and update all eight outputs together, in the same cycle done is high.
- That cycle is exactly 53 clock edges after the edge that accepted the 29th byte.
- Outputs keep their values at all other times, including during a new load and a new computation.
REQ-021 SHALL ignore in_valid while busy; pixels and weights are not retained between runs, so every run needs a full 29-byte load.

Reset
REQ-022 SHALL, while rst=0, immediately force:
- state LOAD and all counters to 0
- accumulator to 0
- done=0, busy=0, in_ready=1 on release
- all eight cell outputs to 8'd0
REQ-023 SHALL abandon any partial load or computation when reset is asserted mid-operation; no done pulse and no output update follow from the abandoned run.

Structure
REQ-024 SHALL take the following from shared package cnn_pkg:
- data width 8
- accumulator width 21
- pixel count 16, kernel tap counts 9 and 4, load length 29
- the state enumeration
REQ-025 SHALL place the multiply-accumulate datapath in one sub-module, mac_unit (inputs: clear, enable, pixel, weight; output: accumulator).
REQ-026 SHALL connect its eight cell outputs directly to the matching inputs of the downstream display stage.

Verification
REQ-027 SHALL be covered by these directed scenarios:
- Uniform: all pixels 16, all k3=1, all k2=1, SHIFT=4 -> cell_3x3_* = 9, cell_2x2_* = 4; done pulses exactly 53 cycles after the last load handshake.
- Saturation: all pixels 255, all weights 127 -> every output 255; accumulator 291465, no overflow.
- Negative clamp: pixels 255, weights -128 -> every output 0.
- Backpressure and gaps: in_valid toggled randomly over 29 bytes of a ramp image p[r][c] = 4r+c, identity-centre k3 (k3[1][1]=16, others 0), k2 = {16,0,0,0} -> cell_3x3 = 5, 6, 9, 10 and cell_2x2 = 0, 2, 8, 10; bytes presented while busy are not consumed.
- Reset mid-operation: assert rst during CONV3 of the second run -> outputs 0 immediately, no done pulse; a full reload afterwards gives correct results.
- Hold: after a completed run, load 20 bytes and pause -> outputs unchanged and busy stays 0.
